crossing_ctrl: RTL and testbench
================================

// Module: crossing_ctrl
// PURPOSE
//   Game-rule engine for the cat/dog/mouse river-crossing puzzle. Consumes debounced
//   button levels plus 1 Hz / 4 Hz tick enables. Produces bank positions, canoe-rider
//   flags, trip count, BCD countdown and game state. These outputs feed the matrix/7-seg
//   display scanner directly downstream.
// PARAMETERS
//   CROSS_TICKS  4  tick_4hz pulses a crossing takes (4 = 1 s)
//   TIME_TENS    6  countdown start, tens digit (BCD)
//   TIME_ONES    0  countdown start, ones digit (BCD)
//   MOVE_LIMIT   7  trip limit; used only with MOVE_LIMIT_EN
// PORTS
//   clk_1kHz        in   1  system clock
//   rst_n           in   1  synchronous reset, active-low
//   tick_1hz        in   1  one-cycle enable, 1 Hz
//   tick_4hz        in   1  one-cycle enable, 4 Hz
//   start           in   1  game-enable switch (level)
//   btn_cat         in   1  debounced level
//   btn_dog         in   1  debounced level
//   btn_mouse       in   1  debounced level
//   btn_go          in   1  debounced level; launches canoe
//   cat_pos         out  1  0 = left bank, 1 = right bank
//   dog_pos         out  1  0 = left bank, 1 = right bank
//   mouse_pos       out  1  0 = left bank, 1 = right bank
//   canoe_pos       out  1  0 = left bank, 1 = right bank
//   cat_crossing    out  1  animal is aboard canoe
//   dog_crossing    out  1  animal is aboard canoe
//   mouse_crossing  out  1  animal is aboard canoe
//   canoe_crossing  out  1  canoe in transit
//   cnt_canoe       out  4  completed trips, saturates at 15
//   ones            out  4  countdown ones digit, BCD
//   tens            out  4  countdown tens digit, BCD
//   game_state      out  2  0 = fail, 1 = success, 2 = continue
// BEHAVIOUR
//   - Every output is registered.
//   - Reset (rst_n=0 at clk edge) values: all *_pos 0, all *_crossing 0, cnt_canoe 0,
//     tens/ones = TIME_TENS/TIME_ONES, game_state 2, FSM in IDLE.
//   - Button inputs are rising-edge detected against a registered copy.
//     - A press is 1 cycle wide; its effect is visible 1 cycle later.
//     - Held buttons never repeat.
//   - FSM states: IDLE, PLAY, CROSS, WIN, LOSE.
//   - Any state: start=0 -> IDLE with reset values on the next cycle.
//   - IDLE: start=1 -> PLAY.
//   - PLAY:
//     - Animal press, animal on canoe bank, no rider -> animal boards (crossing=1).
//     - Press of the current rider -> it unboards.
//     - Press while another animal rides, or animal on far bank -> ignored.
//     - Two or more animal presses in the same cycle -> all ignored.
//     - go press -> CROSS: canoe_crossing=1, load counter with CROSS_TICKS.
//     - go press in the same cycle as an animal press -> go wins, animal press dropped.
//   - CROSS:
//     - Buttons ignored. Each tick_4hz decrements the counter.
//     - On the tick that reaches 0 (arrival), in one cycle:
//       - canoe_pos and the rider's pos toggle;
//       - all crossing flags clear;
//       - cnt_canoe increments, saturating at 15;
//       - rules are evaluated.
//   - Rules, checked on the bank opposite the new canoe_pos:
//     - cat+mouse there -> LOSE; cat+dog there -> LOSE.
//     - All animals and canoe at 1 -> WIN. Otherwise -> PLAY.
//   - Countdown:
//     - Decrements on tick_1hz in PLAY and CROSS only.
//     - ones 0 -> 9 with tens-1. Reaching 00 -> LOSE.
//     - Arrival in the same cycle as 00 is evaluated first; WIN overrides the timeout.
//   - WIN: game_state 1. LOSE: game_state 0. All other states: game_state 2.
//     - WIN/LOSE hold positions and timer frozen until start=0 or reset.
//   - Reset mid-crossing: the next edge restores reset values. No partial move persists.
// CONFIGURATION
//   MOVE_LIMIT_EN defined:
//     - On arrival not resulting in WIN, cnt_canoe == MOVE_LIMIT -> LOSE.
//   MOVE_LIMIT_EN undefined:
//     - No trip limit; only the rules and the timer end the game.
// TESTING
//   1. reset, start=1 -> PLAY; game_state=2, tens=6, ones=0, all pos=0.
//   2. Optimal sequence: cat>, <, dog>, cat<, mouse>, <, cat>
//      -> game_state=1, cnt_canoe=7, all pos=1.
//   3. go with empty canoe from start -> arrival: canoe_pos=1, game_state=0, cnt_canoe=1.
//   4. Board mouse, then press dog -> dog_crossing stays 0.
//      Press cat+dog in the same cycle -> no change.
//   5. start=1, 60 tick_1hz pulses, no moves -> digits 59..00; game_state=0 at 00.
//   6. MOVE_LIMIT_EN, MOVE_LIMIT=7, shuttle cat 7 times -> 7th arrival game_state=0.
//      Without the macro -> game_state=2.

Source files
------------

// File: rtl/crossing_ctrl.sv
// Rule engine for the cat/dog/mouse river-crossing puzzle: boarding, canoe trips, win/lose rules, BCD countdown.
// Optional trip limit enabled by defining MOVE_LIMIT_EN.
module crossing_ctrl #(
  parameter int         CROSS_TICKS = 4,
  parameter logic [3:0] TIME_TENS   = 4'd6,
  parameter logic [3:0] TIME_ONES   = 4'd0,
  parameter logic [3:0] MOVE_LIMIT  = 4'd7
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_4hz,
  input  logic       start,
  input  logic       btn_cat,
  input  logic       btn_dog,
  input  logic       btn_mouse,
  input  logic       btn_go,
  output logic       cat_pos,
  output logic       dog_pos,
  output logic       mouse_pos,
  output logic       canoe_pos,
  output logic       cat_crossing,
  output logic       dog_crossing,
  output logic       mouse_crossing,
  output logic       canoe_crossing,
  output logic [3:0] cnt_canoe,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] game_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CROSS = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] GS_FAIL    = 2'd0;
  localparam logic [1:0] GS_WIN     = 2'd1;
  localparam logic [1:0] GS_CONT    = 2'd2;
  localparam logic [7:0] CROSS_LOAD = 8'(CROSS_TICKS);

`ifdef MOVE_LIMIT_EN
  localparam logic LIMIT_ON = 1'b1;
`else
  localparam logic LIMIT_ON = 1'b0;
`endif

  state_t     r_state;
  logic [3:0] r_btn_q;
  logic       r_cat_pos, r_dog_pos, r_mouse_pos, r_canoe_pos;
  logic       r_cat_x, r_dog_x, r_mouse_x, r_canoe_x;
  logic [3:0] r_cnt, r_ones, r_tens;
  logic [1:0] r_gs;
  logic [7:0] r_tick_cnt;

  logic [3:0] w_btn, w_press;
  logic [2:0] w_rider, w_pos, w_board_nx;
  logic       w_one_animal;
  logic [3:0] w_ones_dec, w_tens_dec, w_cnt_nx;
  logic       w_timeout, w_arrive;
  logic       w_cat_nx, w_dog_nx, w_mouse_nx, w_canoe_nx, w_far;
  logic       w_rule_lose, w_win, w_limit_hit;

  assign w_btn   = {btn_go, btn_mouse, btn_dog, btn_cat};
  assign w_press = w_btn & ~r_btn_q;
  assign w_rider = {r_mouse_x, r_dog_x, r_cat_x};
  assign w_pos   = {r_mouse_pos, r_dog_pos, r_cat_pos};

  // Exactly one animal button rising this cycle; simultaneous presses are discarded.
  always_comb begin
    case (w_press[2:0])
      3'b001, 3'b010, 3'b100: w_one_animal = 1'b1;
      default:                w_one_animal = 1'b0;
    endcase
  end

  // Next rider flags: pressing the rider unboards it, an empty canoe accepts an animal on its bank.
  always_comb begin
    w_board_nx = w_rider;
    if (w_one_animal) begin
      if ((w_press[2:0] & w_rider) != 3'b000) begin
        w_board_nx = 3'b000;
      end else if ((w_rider == 3'b000) &&
                   ((w_press[2:0] & ~(w_pos ^ {3{r_canoe_pos}})) != 3'b000)) begin
        w_board_nx = w_press[2:0];
      end else begin
        w_board_nx = w_rider;
      end
    end else begin
      w_board_nx = w_rider;
    end
  end

  // BCD countdown step: ones wraps 0 -> 9 with a borrow from tens.
  always_comb begin
    if (r_ones == 4'd0) begin
      w_ones_dec = 4'd9;
      w_tens_dec = r_tens - 4'd1;
    end else begin
      w_ones_dec = r_ones - 4'd1;
      w_tens_dec = r_tens;
    end
  end

  assign w_timeout = tick_1hz & (w_tens_dec == 4'd0) & (w_ones_dec == 4'd0);
  assign w_arrive  = tick_4hz & (r_tick_cnt <= 8'd1);
  assign w_cnt_nx  = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;

  // Arrival outcome, judged on the bank the canoe has just left.
  assign w_cat_nx    = r_cat_pos ^ r_cat_x;
  assign w_dog_nx    = r_dog_pos ^ r_dog_x;
  assign w_mouse_nx  = r_mouse_pos ^ r_mouse_x;
  assign w_canoe_nx  = ~r_canoe_pos;
  assign w_far       = ~w_canoe_nx;
  assign w_rule_lose = (w_cat_nx == w_far) & ((w_mouse_nx == w_far) | (w_dog_nx == w_far));
  assign w_win       = w_cat_nx & w_dog_nx & w_mouse_nx & w_canoe_nx;
  assign w_limit_hit = LIMIT_ON & (w_cnt_nx == MOVE_LIMIT);

  // Registered copy of the buttons for rising-edge detection.
  always_ff @(posedge clk_1kHz) begin
    if (!rst_n) begin
      r_btn_q <= 4'b0000;
    end else begin
      r_btn_q <= w_btn;
    end
  end

  // Game FSM with all display-facing outputs registered.
  always_ff @(posedge clk_1kHz) begin
    if (!rst_n || !start) begin
      r_state     <= S_IDLE;
      r_cat_pos   <= 1'b0;
      r_dog_pos   <= 1'b0;
      r_mouse_pos <= 1'b0;
      r_canoe_pos <= 1'b0;
      r_cat_x     <= 1'b0;
      r_dog_x     <= 1'b0;
      r_mouse_x   <= 1'b0;
      r_canoe_x   <= 1'b0;
      r_cnt       <= 4'd0;
      r_tens      <= TIME_TENS;
      r_ones      <= TIME_ONES;
      r_gs        <= GS_CONT;
      r_tick_cnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (tick_1hz) begin
            r_ones <= w_ones_dec;
            r_tens <= w_tens_dec;
          end
          if (w_timeout) begin
            r_state <= S_LOSE;
            r_gs    <= GS_FAIL;
          end else if (w_press[3]) begin
            r_state    <= S_CROSS;
            r_canoe_x  <= 1'b1;
            r_tick_cnt <= CROSS_LOAD;
          end else begin
            {r_mouse_x, r_dog_x, r_cat_x} <= w_board_nx;
          end
        end
        S_CROSS: begin
          if (tick_1hz) begin
            r_ones <= w_ones_dec;
            r_tens <= w_tens_dec;
          end
          if (tick_4hz && (r_tick_cnt != 8'd0)) begin
            r_tick_cnt <= r_tick_cnt - 8'd1;
          end
          if (w_arrive) begin
            r_cat_pos   <= w_cat_nx;
            r_dog_pos   <= w_dog_nx;
            r_mouse_pos <= w_mouse_nx;
            r_canoe_pos <= w_canoe_nx;
            r_cat_x     <= 1'b0;
            r_dog_x     <= 1'b0;
            r_mouse_x   <= 1'b0;
            r_canoe_x   <= 1'b0;
            r_cnt       <= w_cnt_nx;
            // A winning arrival beats a simultaneous timeout.
            if (w_win) begin
              r_state <= S_WIN;
              r_gs    <= GS_WIN;
            end else if (w_rule_lose || w_limit_hit || w_timeout) begin
              r_state <= S_LOSE;
              r_gs    <= GS_FAIL;
            end else begin
              r_state <= S_PLAY;
            end
          end else if (w_timeout) begin
            r_state <= S_LOSE;
            r_gs    <= GS_FAIL;
          end
        end
        S_WIN, S_LOSE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cat_pos        = r_cat_pos;
  assign dog_pos        = r_dog_pos;
  assign mouse_pos      = r_mouse_pos;
  assign canoe_pos      = r_canoe_pos;
  assign cat_crossing   = r_cat_x;
  assign dog_crossing   = r_dog_x;
  assign mouse_crossing = r_mouse_x;
  assign canoe_crossing = r_canoe_x;
  assign cnt_canoe      = r_cnt;
  assign ones           = r_ones;
  assign tens           = r_tens;
  assign game_state     = r_gs;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Directed bench for crossing_ctrl: a puzzle-level model checked every cycle plus literal checkpoints.
module tb_crossing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick_1hz, tick_4hz, start, btn_cat, btn_dog, btn_mouse, btn_go;
  logic       cat_pos, dog_pos, mouse_pos, canoe_pos;
  logic       cat_crossing, dog_crossing, mouse_crossing, canoe_crossing;
  logic [3:0] cnt_canoe, ones, tens;
  logic [1:0] game_state;

  crossing_ctrl dut (
    .clk_1kHz(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_4hz(tick_4hz), .start(start),
    .btn_cat(btn_cat), .btn_dog(btn_dog), .btn_mouse(btn_mouse), .btn_go(btn_go),
    .cat_pos(cat_pos), .dog_pos(dog_pos), .mouse_pos(mouse_pos), .canoe_pos(canoe_pos),
    .cat_crossing(cat_crossing), .dog_crossing(dog_crossing),
    .mouse_crossing(mouse_crossing), .canoe_crossing(canoe_crossing),
    .cnt_canoe(cnt_canoe), .ones(ones), .tens(tens), .game_state(game_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk   = 1'b0;

  // Puzzle-level model: index 0 cat, 1 dog, 2 mouse, 3 canoe; time kept in whole seconds.
  localparam int M_IDLE = 0, M_PLAY = 1, M_SAIL = 2, M_WON = 3, M_LOST = 4;
  localparam int TRIP_LEN = 4;
  int m_phase, m_rider, m_legs, m_trips, m_secs;
  int m_pos[4];
  bit m_sail;
  bit m_prev[4];

  task automatic model_reset();
    m_phase = M_IDLE;
    for (int k = 0; k < 4; k++) m_pos[k] = 0;
    m_rider = -1; m_sail = 1'b0; m_legs = 0; m_trips = 0; m_secs = 60;
  endtask

  always @(posedge clk) begin : model
    bit bt[4];
    bit pr[4];
    int npress, who, far;
    bit timeout, arrived, bad, win, limit;
    bt = '{btn_cat, btn_dog, btn_mouse, btn_go};
    for (int k = 0; k < 4; k++) begin
      pr[k] = bt[k] && !m_prev[k];
      m_prev[k] = rst_n ? bt[k] : 1'b0;
    end
    if (!rst_n || !start) begin
      model_reset();
    end else begin
      timeout = 1'b0;
      if (tick_1hz && (m_phase == M_PLAY || m_phase == M_SAIL)) begin
        m_secs = m_secs - 1;
        timeout = (m_secs == 0);
      end
      case (m_phase)
        M_IDLE: m_phase = M_PLAY;
        M_PLAY: begin
          npress = int'(pr[0]) + int'(pr[1]) + int'(pr[2]);
          if (timeout) m_phase = M_LOST;
          else if (pr[3]) begin
            m_phase = M_SAIL; m_sail = 1'b1; m_legs = TRIP_LEN;
          end else if (npress == 1) begin
            who = pr[0] ? 0 : (pr[1] ? 1 : 2);
            if (m_rider == who) m_rider = -1;
            else if (m_rider < 0 && m_pos[who] == m_pos[3]) m_rider = who;
          end
        end
        M_SAIL: begin
          arrived = 1'b0;
          if (tick_4hz) begin
            if (m_legs > 0) m_legs = m_legs - 1;
            arrived = (m_legs == 0);
          end
          if (arrived) begin
            m_pos[3] = 1 - m_pos[3];
            if (m_rider >= 0) m_pos[m_rider] = 1 - m_pos[m_rider];
            m_rider = -1; m_sail = 1'b0;
            if (m_trips < 15) m_trips = m_trips + 1;
            far = 1 - m_pos[3];
            bad = (m_pos[0] == far) && (m_pos[2] == far || m_pos[1] == far);
            win = (m_pos[0] == 1) && (m_pos[1] == 1) && (m_pos[2] == 1) && (m_pos[3] == 1);
`ifdef MOVE_LIMIT_EN
            limit = (m_trips == 7);
`else
            limit = 1'b0;
`endif
            if (win) m_phase = M_WON;
            else if (bad || limit || timeout) m_phase = M_LOST;
            else m_phase = M_PLAY;
          end else if (timeout) begin
            m_phase = M_LOST;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [21:0] model_vec();
    logic [1:0] gs;
    gs = (m_phase == M_WON) ? 2'd1 : ((m_phase == M_LOST) ? 2'd0 : 2'd2);
    return {m_pos[0] != 0, m_pos[1] != 0, m_pos[2] != 0, m_pos[3] != 0,
            m_rider == 0, m_rider == 1, m_rider == 2, m_sail,
            4'(m_trips), 4'(m_secs / 10), 4'(m_secs % 10), gs};
  endfunction

  wire [21:0] dut_vec = {cat_pos, dog_pos, mouse_pos, canoe_pos,
                         cat_crossing, dog_crossing, mouse_crossing, canoe_crossing,
                         cnt_canoe, tens, ones, game_state};

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      logic [21:0] exp_v;
      exp_v = model_vec();
      n_vec++;
      if (dut_vec !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, dut_vec, exp_v);
      end
    end
  end

  task automatic check(string nm, logic [7:0] got, logic [7:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp_v);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [3:0] m);
    {btn_go, btn_mouse, btn_dog, btn_cat} = m;
    cyc(1);
    {btn_go, btn_mouse, btn_dog, btn_cat} = 4'b0000;
    cyc(2);
  endtask

  task automatic sec();
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1);
  endtask

  task automatic trip(logic [2:0] who, bit sec_on_last);
    if (who != 3'b000) press({1'b0, who});
    press(4'b1000);
    for (int i = 0; i < 4; i++) begin
      tick_4hz = 1'b1;
      if (i == 3 && sec_on_last) tick_1hz = 1'b1;
      cyc(1);
      tick_4hz = 1'b0; tick_1hz = 1'b0;
      cyc(1);
    end
    cyc(1);
  endtask

  task automatic restart();
    start = 1'b0; cyc(2); start = 1'b1; cyc(2);
  endtask

  task automatic optimal(bit final_with_sec);
    trip(3'b001, 1'b0); trip(3'b000, 1'b0); trip(3'b010, 1'b0);
    trip(3'b001, 1'b0); trip(3'b100, 1'b0); trip(3'b000, 1'b0);
    trip(3'b001, final_with_sec);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick_1hz = 1'b0; tick_4hz = 1'b0;
    btn_cat = 1'b0; btn_dog = 1'b0; btn_mouse = 1'b0; btn_go = 1'b0;
    cyc(3);
    chk = 1'b1;
    check("reset_state", 8'(game_state), 8'd2);
    check("reset_timer", {tens, ones}, 8'h60);
    check("reset_pos", 8'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 8'h0);

    rst_n = 1'b1; start = 1'b1; cyc(2);
    check("play_state", 8'(game_state), 8'd2);
    check("play_timer", {tens, ones}, 8'h60);

    optimal(1'b0);
    check("win_state", 8'(game_state), 8'd1);
    check("win_trips", 8'(cnt_canoe), 8'd7);
    check("win_pos", 8'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 8'hF);
    sec();
    check("win_timer_frozen", {tens, ones}, 8'h60);

    restart();
    trip(3'b000, 1'b0);
    check("empty_go_canoe", 8'(canoe_pos), 8'd1);
    check("empty_go_state", 8'(game_state), 8'd0);
    check("empty_go_trips", 8'(cnt_canoe), 8'd1);

    restart();
    press(4'b0100);
    check("board_mouse", 8'(mouse_crossing), 8'd1);
    press(4'b0010);
    check("dog_refused", 8'(dog_crossing), 8'd0);
    press(4'b0100);
    check("unboard_mouse", 8'(mouse_crossing), 8'd0);
    press(4'b0011);
    check("double_press", 8'({cat_crossing, dog_crossing}), 8'd0);
    btn_cat = 1'b1; cyc(6);
    check("held_no_repeat", 8'(cat_crossing), 8'd1);
    btn_cat = 1'b0; cyc(2);
    press(4'b0001);
    check("unboard_cat", 8'(cat_crossing), 8'd0);
    press(4'b1100);
    check("go_wins", 8'({canoe_crossing, mouse_crossing}), 8'b10);
    tick_4hz = 1'b1; cyc(1); tick_4hz = 1'b0; cyc(1);
    tick_4hz = 1'b1; cyc(1); tick_4hz = 1'b0;
    rst_n = 1'b0; cyc(1);
    check("reset_mid_cross", 8'({canoe_crossing, canoe_pos, cnt_canoe}), 8'h00);
    rst_n = 1'b1; cyc(2);

    restart();
    sec();
    check("timer_59", {tens, ones}, 8'h59);
    repeat (58) sec();
    check("timer_01", {tens, ones}, 8'h01);
    check("timer_01_state", 8'(game_state), 8'd2);
    sec();
    check("timer_00", {tens, ones}, 8'h00);
    check("timeout_state", 8'(game_state), 8'd0);
    sec();
    check("timer_frozen", {tens, ones}, 8'h00);

    restart();
    repeat (59) sec();
    optimal(1'b1);
    check("win_beats_timeout", 8'(game_state), 8'd1);
    check("win_timeout_timer", {tens, ones}, 8'h00);

    restart();
    repeat (7) trip(3'b001, 1'b0);
    check("shuttle_trips", 8'(cnt_canoe), 8'd7);
`ifdef MOVE_LIMIT_EN
    check("limit_state", 8'(game_state), 8'd0);
`else
    check("no_limit_state", 8'(game_state), 8'd2);
    repeat (9) trip(3'b001, 1'b0);
    check("trips_saturate", 8'(cnt_canoe), 8'd15);
`endif

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
